// File: rtl/mult_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier.
// Borrows the shared 16-bit ALU for each partial-product add (request/grant)
// and runs one bit per SHIFT cycle, so a multiply takes
// 16 + popcount(opB) + stall cycles before the DONE cycle.
module mult_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] opA,
    input  logic [15:0] opB,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic        aluReq,
    input  logic        aluGnt,
    output logic [15:0] aluA,
    output logic [15:0] aluB,
    output logic [2:0]  aluOp,
    output logic        aluCin,
    output logic        aluInvA,
    output logic        aluInvB,
    output logic        aluSign,
    input  logic [15:0] aluOut,
    input  logic        aluOfl
);

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADD   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0]    ALU_OP_ADD = 3'h4;
    localparam logic [CW-1:0] CNT_LAST   = CW'(W - 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [W-1:0]  m;
    logic [W-1:0]  p_hi;
    logic [W-1:0]  p_lo;
    logic          carry;
    logic [CW-1:0] cnt;
    logic [2*W:0]  acc_sh;

    // ALU operands come straight from the datapath registers; control is fixed to unsigned add
    assign aluA    = p_hi;
    assign aluB    = m;
    assign aluOp   = ALU_OP_ADD;
    assign aluCin  = 1'b0;
    assign aluInvA = 1'b0;
    assign aluInvB = 1'b0;
    assign aluSign = 1'b0;

    // {carry,p_hi,p_lo} shifted right by one, zero entering at the top
    assign acc_sh = {1'b0, carry, p_hi, p_lo[W-1:1]};

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = opB[0] ? S_ADD : S_SHIFT;
                end
            end
            S_ADD: begin
                if (aluGnt) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = S_DONE;
                end else if (p_lo[1]) begin
                    state_nxt = S_ADD;
                end else begin
                    state_nxt = S_SHIFT;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register plus status outputs registered from the next-state decode
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            aluReq <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy   <= (state_nxt != S_IDLE);
            done   <= (state_nxt == S_DONE);
            aluReq <= (state_nxt == S_ADD);
        end
    end

    // Datapath: load on accept, take ALU sum on grant, shift one bit per SHIFT
    always_ff @(posedge clk) begin
        if (!rst) begin
            m       <= '0;
            p_hi    <= '0;
            p_lo    <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        m     <= opA;
                        p_hi  <= '0;
                        p_lo  <= opB;
                        carry <= 1'b0;
                        cnt   <= '0;
                    end
                end
                S_ADD: begin
                    if (aluGnt) begin
                        p_hi  <= aluOut;
                        carry <= aluOfl;
                    end
                end
                S_SHIFT: begin
                    carry <= acc_sh[2*W];
                    p_hi  <= acc_sh[2*W-1:W];
                    p_lo  <= acc_sh[W-1:0];
                    // Counter parks at its last value; only a new start reloads it
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        product <= acc_sh[2*W-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
// Randomized and directed checks of mult_seq against plain-arithmetic expectations.
module tb_mult_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] opA;
    logic [15:0] opB;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic        aluReq;
    logic        aluGnt;
    logic [15:0] aluA;
    logic [15:0] aluB;
    logic [2:0]  aluOp;
    logic        aluCin;
    logic        aluInvA;
    logic        aluInvB;
    logic        aluSign;
    logic [15:0] aluOut;
    logic        aluOfl;

    logic [15:0] junk;
    logic        junk_c;
    logic [16:0] alu_sum;

    int n_cmp;
    int n_bad;

    mult_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .opA     (opA),
        .opB     (opB),
        .busy    (busy),
        .done    (done),
        .product (product),
        .aluReq  (aluReq),
        .aluGnt  (aluGnt),
        .aluA    (aluA),
        .aluB    (aluB),
        .aluOp   (aluOp),
        .aluCin  (aluCin),
        .aluInvA (aluInvA),
        .aluInvB (aluInvB),
        .aluSign (aluSign),
        .aluOut  (aluOut),
        .aluOfl  (aluOfl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU stand-in: real sum when granted, garbage otherwise
    assign alu_sum = {1'b0, aluA} + {1'b0, aluB};
    assign aluOut  = aluGnt ? alu_sum[15:0] : junk;
    assign aluOfl  = aluGnt ? alu_sum[16]   : junk_c;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // mode 0: always grant, 1: random stalls, 2: hold grant low for first 5 ADD cycles
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input int mode,
                           input bit mid_start, input bit done_start);
        int          cyc;
        int          stalls;
        int          reqs;
        int          first_hold;
        int          pc;
        bit          seen;
        logic [31:0] exp_p;
        exp_p = 32'(a) * 32'(b);
        pc    = $countones(b);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        opA    = a;
        opB    = b;
        start  = 1'b1;
        aluGnt = 1'($urandom % 2);
        @(negedge clk);
        start      = 1'b0;
        opA        = 16'($urandom);
        opB        = 16'($urandom);
        cyc        = 1;
        stalls     = 0;
        reqs       = 0;
        first_hold = 0;
        seen       = 1'b0;
        while (cyc <= 2000 && !seen) begin
            junk   = 16'($urandom);
            junk_c = 1'($urandom);
            chk("alu_ctrl", 32'({aluOp, aluCin, aluInvA, aluInvB, aluSign}), 32'h40);
            if (done) begin
                seen = 1'b1;
                chk("latency", 32'(cyc), 32'(16 + pc + stalls + 1));
                chk("product", product, exp_p);
                chk("done_busy", 32'(busy), 32'd1);
                chk("alureq_cnt", 32'(reqs), 32'(pc + stalls));
                if (done_start) begin
                    start = 1'b1;
                    opA   = 16'($urandom);
                    opB   = 16'hFFFF;
                end
            end else begin
                chk("busy", 32'(busy), 32'd1);
                if (aluReq) begin
                    reqs++;
                    chk("aluB", 32'(aluB), 32'(a));
                    if (mode == 2 && first_hold < 5) begin
                        chk("hold_aluA", 32'(aluA), 32'd0);
                        aluGnt = 1'b0;
                        first_hold++;
                    end else if (mode == 1) begin
                        aluGnt = (($urandom % 3) != 0);
                    end else begin
                        aluGnt = 1'b1;
                    end
                    if (!aluGnt) stalls++;
                end else begin
                    aluGnt = 1'($urandom % 2);
                end
                if (mid_start && cyc == 5) begin
                    start = 1'b1;
                    opA   = 16'($urandom);
                    opB   = 16'($urandom);
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (!seen) chk("timeout", 32'd0, 32'd1);
        @(negedge clk);
        start = 1'b0;
        chk("post_done", 32'(done), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        chk("held_product", product, exp_p);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b0;
        start  = 1'b0;
        opA    = '0;
        opB    = '0;
        aluGnt = 1'b0;
        junk   = '0;
        junk_c = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_req", 32'(aluReq), 32'd0);
        chk("rst_product", product, 32'd0);
        rst = 1'b1;

        // Directed scenarios
        run_mul(16'd3, 16'd5, 0, 1'b0, 1'b0);
        run_mul(16'hFFFF, 16'hFFFF, 0, 1'b0, 1'b0);
        run_mul(16'h1234, 16'h0000, 0, 1'b0, 1'b0);
        run_mul(16'd7, 16'd1, 2, 1'b0, 1'b0);
        run_mul(16'hABCD, 16'h0F0F, 0, 1'b1, 1'b0);
        run_mul(16'h00FF, 16'h8001, 1, 1'b0, 1'b1);
        run_mul(16'h8000, 16'h8000, 1, 1'b0, 1'b0);

        // Reset at cycle 8 of a multiply aborts it and clears the product
        @(negedge clk);
        opA   = 16'h0009;
        opB   = 16'h0055;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_product", product, 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_req", 32'(aluReq), 32'd0);
        // Reset wins over a simultaneous start
        start = 1'b1;
        opA   = 16'd2;
        opB   = 16'd3;
        @(negedge clk);
        chk("rst_prio_busy", 32'(busy), 32'd0);
        start = 1'b0;
        rst   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("no_done_after_abort", 32'(done), 32'd0);
        end
        run_mul(16'd9, 16'h0055, 0, 1'b0, 1'b0);

        // Random operands with random grant stalls
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom % 8)
                0: rb = 16'h0000;
                1: rb = 16'hFFFF;
                2: ra = 16'hFFFF;
                default: ;
            endcase
            run_mul(ra, rb, 1, (($urandom % 10) == 0), (($urandom % 10) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
